// File: rtl/max1112x_responder.sv
// max1112x_responder
// SPI responder that behaves like a MAX1112x-family 12-bit ADC. It decodes
// 16-bit command frames on MOSI and returns {channel_id, sample} frames on
// MISO, one frame behind the command that selected the channel. All SPI pins
// are oversampled in the clk domain; sample values come from a parallel port.

module max1112x_responder #(
  parameter int C_channels    = 4,
  parameter int C_sync_stages = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spi_csn,
  input  logic                      spi_clk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  input  logic [C_channels*12-1:0]  sample_data,
  output logic [15:0]               cmd,
  output logic                      cmd_valid,
  output logic                      err_frame,
  output logic [15:0]               frame_count,
  output logic [3:0]                chan
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2
  } state_t;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_AUTO  = 1'b1
  } mode_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [C_sync_stages-1:0] csn_sync;
  logic [C_sync_stages-1:0] sclk_sync;
  logic [C_sync_stages-1:0] mosi_sync;

  logic csn_s;
  logic sclk_s;
  logic mosi_s;

  assign csn_s  = csn_sync[C_sync_stages-1];
  assign sclk_s = sclk_sync[C_sync_stages-1];
  assign mosi_s = mosi_sync[C_sync_stages-1];

  // Synchronizer chains for the three asynchronous SPI inputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // so the chain really delays by one clk per stage instead of collapsing.
    // The chains reset to 0 so a CSN held low across reset never looks high
    // for a moment and starts a phantom frame.
    if (reset) begin
      csn_sync  <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      csn_sync  <= {csn_sync[C_sync_stages-2:0],  spi_csn};
      sclk_sync <= {sclk_sync[C_sync_stages-2:0], spi_clk};
      mosi_sync <= {mosi_sync[C_sync_stages-2:0], spi_mosi};
    end
  end

  // Edge-detect registers and registered events; level and MOSI stay aligned.
  logic csn_lvl;
  logic sclk_d;
  logic mosi_bit;
  logic csn_fall;
  logic csn_rise;
  logic sclk_rise;
  logic sclk_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      csn_lvl   <= 1'b0;
      sclk_d    <= 1'b0;
      mosi_bit  <= 1'b0;
      csn_fall  <= 1'b0;
      csn_rise  <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      csn_lvl   <= csn_s;
      sclk_d    <= sclk_s;
      mosi_bit  <= mosi_s;
      csn_fall  <=  csn_lvl & ~csn_s;
      csn_rise  <= ~csn_lvl &  csn_s;
      sclk_rise <= ~sclk_d  &  sclk_s;
      sclk_fall <=  sclk_d  & ~sclk_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath helpers
  // ---------------------------------------------------------------------------
  state_t      state;
  mode_t       mode;
  logic [3:0]  limit;
  logic [15:0] tx;
  logic [15:0] rx;
  logic [4:0]  bit_cnt;

  // Sample for the currently selected channel; unimplemented channels read 0.
  logic [11:0] snap_data;

  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it an unmatched chan would infer a latch.
    snap_data = 12'h000;
    for (int i = 0; i < C_channels; i++) begin
      if (chan == 4'(i)) snap_data = sample_data[i*12 +: 12];
    end
  end

  // Receive shift and saturating bit count including a bit that arrives in
  // the same cycle as the frame close, so that bit is counted first.
  logic [15:0] rx_next;
  logic [4:0]  cnt_next;

  always_comb begin
    rx_next  = rx;
    cnt_next = bit_cnt;
    if (sclk_rise) begin
      rx_next = {rx[14:0], mosi_bit};
      if (bit_cnt != 5'd31) cnt_next = bit_cnt + 5'd1;
    end
  end

  // Scan-state update for a good frame carrying rx_next as its command.
  logic [3:0] scan;
  logic [3:0] chsel;
  logic [3:0] chan_next;
  mode_t      mode_next;
  logic [3:0] limit_next;

  assign scan  = rx_next[14:11];
  assign chsel = rx_next[10:7];

  always_comb begin
    mode_next  = mode;
    limit_next = limit;
    if (mode == MODE_AUTO) chan_next = (chan == limit) ? 4'd0 : chan + 4'd1;
    else                   chan_next = chan;
    if (!rx_next[15]) begin
      if (scan == 4'd1) begin
        chan_next = chsel;
        mode_next = MODE_FIXED;
      end else if (scan >= 4'd2) begin
        chan_next  = 4'd0;
        mode_next  = MODE_AUTO;
        limit_next = chsel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine with registered outputs
  // ---------------------------------------------------------------------------
  // Tracks CSN framing, shifts TX/RX, and closes frames into cmd/chan updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_HIGH;
      mode        <= MODE_FIXED;
      limit       <= 4'd0;
      tx          <= 16'h0000;
      rx          <= 16'h0000;
      bit_cnt     <= 5'd0;
      spi_miso    <= 1'b0;
      cmd         <= 16'h0000;
      cmd_valid   <= 1'b0;
      err_frame   <= 1'b0;
      frame_count <= 16'h0000;
      chan        <= 4'd0;
    end else begin
      cmd_valid <= 1'b0;
      err_frame <= 1'b0;
      case (state)
        WAIT_HIGH: begin
          spi_miso <= 1'b0;
          if (csn_lvl) state <= IDLE;
        end

        IDLE: begin
          spi_miso <= 1'b0;
          if (csn_fall) begin
            state    <= FRAME;
            tx       <= {chan, snap_data};
            rx       <= 16'h0000;
            bit_cnt  <= 5'd0;
            spi_miso <= chan[3];
          end
        end

        FRAME: begin
          rx      <= rx_next;
          bit_cnt <= cnt_next;
          if (csn_rise) begin
            state    <= IDLE;
            spi_miso <= 1'b0;
            if (cnt_next == 5'd16) begin
              cmd         <= rx_next;
              cmd_valid   <= 1'b1;
              frame_count <= frame_count + 16'd1;
              chan        <= chan_next;
              mode        <= mode_next;
              limit       <= limit_next;
            end else begin
              err_frame <= 1'b1;
            end
          end else if (sclk_fall) begin
            tx       <= {tx[14:0], 1'b0};
            spi_miso <= tx[14];
          end
        end

        default: begin
          state    <= WAIT_HIGH;
          spi_miso <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max1112x_responder.sv
// Directed bench for max1112x_responder: an SPI master task drives frames,
// expected MISO words go through a scoreboard queue, and side outputs are
// compared against constants derived from the command sequence.

module tb_max1112x_responder;

  localparam int C_channels = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     spi_csn = 1'b1;
  logic                     spi_clk = 1'b0;
  logic                     spi_mosi = 1'b0;
  logic                     spi_miso;
  logic [C_channels*12-1:0] sample_data;
  logic [15:0]              cmd;
  logic                     cmd_valid;
  logic                     err_frame;
  logic [15:0]              frame_count;
  logic [3:0]               chan;

  int n_total  = 0;
  int n_passed = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];

  max1112x_responder #(
    .C_channels   (C_channels),
    .C_sync_stages(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_csn     (spi_csn),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .sample_data (sample_data),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .err_frame   (err_frame),
    .frame_count (frame_count),
    .chan        (chan)
  );

  always #5 clk = ~clk;

  // Pulse counters: a stuck-high pulse shows up as an inflated count.
  always @(posedge clk) begin
    if (cmd_valid === 1'b1) n_valid++;
    if (err_frame === 1'b1) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SPI mode-0 transfer of nbits; MISO is sampled just before each SCLK rise.
  task automatic spi_xfer(input logic [31:0] mosi_word, input int nbits,
                          output logic [31:0] miso_word);
    miso_word = 32'h0;
    @(negedge clk);
    spi_csn  = 1'b0;
    spi_mosi = mosi_word[nbits-1];
    repeat (6) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = mosi_word[i];
      repeat (5) @(negedge clk);
      miso_word = {miso_word[30:0], spi_miso};
      spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Push the expected response, run the frame, pop and compare.
  task automatic frame_chk(input string tag, input logic [31:0] mosi_word,
                           input int nbits, input logic [31:0] exp_resp);
    logic [31:0] got;
    exp_q.push_back(exp_resp);
    spi_xfer(mosi_word, nbits, got);
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] got;
    logic        miso_seen;
    int          v0;
    int          e0;

    sample_data = {12'hDEF, 12'hABC, 12'h456, 12'h123};

    // 1: reset with CSN high
    repeat (5) @(negedge clk);
    check("miso_in_reset", {31'b0, spi_miso}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_miso",  {31'b0, spi_miso}, 32'h0);
    check("rst_cmd",   {16'b0, cmd}, 32'h0);
    check("rst_fc",    {16'b0, frame_count}, 32'h0);
    check("rst_chan",  {28'b0, chan}, 32'h0);
    check("rst_pulses", n_valid + n_err, 32'h0);

    // 2: manual select of channel 2, pipelined response
    frame_chk("resp_0900", 32'h0900, 16, 32'h0000_0123);
    check("chan_after_0900", {28'b0, chan}, 32'h2);
    check("cmd_after_0900",  {16'b0, cmd}, 32'h0900);
    check("fc_after_0900",   {16'b0, frame_count}, 32'h1);
    frame_chk("resp_ch2", 32'h0000, 16, 32'h0000_2ABC);
    check("valid_pulses_2", n_valid, 2);
    check("fc_2",           {16'b0, frame_count}, 32'h2);
    check("chan_fixed",     {28'b0, chan}, 32'h2);

    // 3: auto scan 0..3
    frame_chk("resp_1180", 32'h1180, 16, 32'h0000_2ABC);
    check("chan_auto_start", {28'b0, chan}, 32'h0);
    frame_chk("auto_0", 32'h0000, 16, 32'h0000_0123);
    frame_chk("auto_1", 32'h0000, 16, 32'h0000_1456);
    frame_chk("auto_2", 32'h0000, 16, 32'h0000_2ABC);
    frame_chk("auto_3", 32'h0000, 16, 32'h0000_3DEF);
    frame_chk("auto_4", 32'h0000, 16, 32'h0000_0123);
    check("fc_3",    {16'b0, frame_count}, 32'h8);
    check("chan_3",  {28'b0, chan}, 32'h1);

    // 4: short and long frames are rejected
    frame_chk("short_resp", 32'h0000_0FFF, 12, 32'h0000_0145);
    check("err_short",   n_err, 1);
    frame_chk("long_resp",  32'h000F_FFFF, 20, 32'h0001_4560);
    check("err_long",    n_err, 2);
    check("valid_err",   n_valid, 8);
    check("cmd_err",     {16'b0, cmd}, 32'h0000);
    check("chan_err",    {28'b0, chan}, 32'h1);
    check("fc_err",      {16'b0, frame_count}, 32'h8);

    // 5: channel beyond C_channels reports ID with zero data
    frame_chk("resp_0c80", 32'h0C80, 16, 32'h0000_1456);
    check("chan_9", {28'b0, chan}, 32'h9);
    frame_chk("resp_ch9", 32'h0000, 16, 32'h0000_9000);
    check("fc_5", {16'b0, frame_count}, 32'd10);

    // 6: reset in the middle of a frame
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      spi_mosi = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    miso_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      repeat (5) @(negedge clk);
      miso_seen = miso_seen | spi_miso;
      spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      miso_seen = miso_seen | spi_miso;
      spi_clk = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi_csn = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_miso",   {31'b0, miso_seen}, 32'h0);
    check("abort_valid",  n_valid - v0, 0);
    check("abort_err",    n_err - e0, 0);
    check("abort_fc",     {16'b0, frame_count}, 32'h0);
    check("abort_chan",   {28'b0, chan}, 32'h0);
    frame_chk("post_abort", 32'h0000, 16, 32'h0000_0123);
    check("post_abort_fc", {16'b0, frame_count}, 32'h1);

    // frame_count wraps from 0xFFFF to 0
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    repeat (2) @(negedge clk);
    frame_chk("wrap_resp", 32'h0000, 16, 32'h0000_0123);
    check("fc_wrap", {16'b0, frame_count}, 32'h0);
    check("valid_total", n_valid, 12);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/max1112x_responder.md
# max1112x_responder

Synthesizable SPI responder emulating a MAX1112x-family 12-bit ADC at the far end of the `max1112x_reader` SPI link. It decodes 16-bit command frames on MOSI and returns `{channel_id, sample}` frames on MISO, with a one-frame conversion pipeline like the real chip. Sample values come from a parallel input port, so the reader, ADC hold logic and on-screen hex display can be exercised in simulation or loopback on GP/GN pins without the ADC fitted. All SPI inputs are oversampled in the single system clock domain.

## Interface
- `C_channels`, 4: number of emulated channels, 1..16.
- `C_sync_stages`, 2: synchronizer flops on `spi_csn`/`spi_clk`/`spi_mosi`, 2..3.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  system clock; must be at least 10× the SCLK frequency.
- `reset`  in  1  synchronous, active-high.
- `spi_csn`  in  1  chip select, active low, asynchronous to `clk`.
- `spi_clk`  in  1  SCLK, idle low (mode 0), asynchronous.
- `spi_mosi`  in  1  command data, MSB first.
- `spi_miso`  out  1  response data, MSB first; 0 when not in a frame.
- `sample_data`  in  `C_channels*12`  channel n occupies bits `[12n+11:12n]`.
- `cmd`  out  16  last complete, accepted command word.
- `cmd_valid`  out  1  1-cycle pulse when `cmd` updates.
- `err_frame`  out  1  1-cycle pulse when a frame closes with a bit count other than 16.
- `frame_count`  out  16  good frames received; wraps from 0xFFFF to 0.
- `chan`  out  4  channel to be reported in the next frame.

## Operation
- Input path: `C_sync_stages` flops, then one edge-detect register per line. The block produces the events `csn_fall`, `csn_rise`, `sclk_rise` and `sclk_fall`. MOSI is taken from the synchronized value aligned with `sclk_rise`.
- State machine:
  - WAIT_HIGH (after reset): go to IDLE once the synchronized csn is high.
  - IDLE: on `csn_fall`, go to FRAME.
  - FRAME: on `csn_rise`, go to IDLE.
- On entering FRAME:
  - Snapshot `sample_data[chan]` into a 16-bit TX shift register as `{chan, data12}`.
  - If `chan >= C_channels`, data12 = 12'h000; the ID field is still `chan`.
  - Clear the bit counter; drive `spi_miso` = TX[15].
- In FRAME:
  - `sclk_fall`: shift TX left, filling with 0. `spi_miso` = new TX[15].
  - `sclk_rise`: shift MOSI into RX. The bit counter saturates at 31.
  - After 16 bits, MISO outputs 0.
- On `csn_rise`:
  - If count == 16: `cmd` ← RX, `cmd_valid` pulse, `frame_count` +1, then decode.
  - Otherwise: `err_frame` pulse; `cmd`, `chan` and `frame_count` are unchanged.
- Decode applies only when `cmd[15] == 0` (ADC mode control). Fields: SCAN = `cmd[14:11]`, CHSEL = `cmd[10:7]`.
  - SCAN = 0: no change to scan state.
  - SCAN = 1 (manual): `chan` ← CHSEL; mode = fixed.
  - SCAN ≥ 2 (auto): `chan` ← 0; mode = auto; limit ← CHSEL.
- Words with `cmd[15] == 1` (config/setup registers) are accepted and counted, but do not change the scan state.
- Auto mode: at every good frame end not carrying a mode command, `chan` ← `chan == limit` ? 0 : `chan + 1`.
- Fixed mode: `chan` holds its value.

## Timing
- Reset values:
  - `spi_miso` = 0, `cmd` = 0, `cmd_valid` = 0, `err_frame` = 0, `frame_count` = 0, `chan` = 0.
  - Mode = fixed, limit = 0, state = WAIT_HIGH.
- Event latency: a pin change becomes an event `C_sync_stages+1` clk later. With defaults, `spi_miso` updates 4 clk after the SCLK fall or CSN fall pin edge.
- `cmd_valid`, `err_frame`, `frame_count` and `chan` update in the same cycle, 1 clk after `csn_rise`.
- The response is pipelined: frame N returns the channel selected as a result of frame N-1. The sample value is the one present at the CSN-fall snapshot.
- Simultaneous events:
  - `csn_rise` with `sclk_rise` in the same cycle: the bit is counted first, then the frame closes.
  - `csn_fall` in any state other than IDLE: ignored.
- Reset mid-frame: the frame is abandoned. A fresh frame needs CSN high and then low again. No pulse is issued for the aborted frame.

## Test plan
1. Reset, CSN held high → all outputs 0, `spi_miso` = 0, no pulses.
2. `sample_data` ch0 = 0x123, ch2 = 0xABC. Frame with cmd 0x0900 (SCAN 1, CHSEL 2) → MISO returns 0x0123 and `chan` becomes 2. Next frame → MISO 0x2ABC, `cmd_valid` pulses once, `frame_count` = 2.
3. Cmd 0x1180 (SCAN 2, CHSEL 3), then 5 frames with cmd 0x0000 → reported IDs 0,1,2,3,0 (with `C_channels` = 4).
4. 12-bit short frame and 20-bit long frame → `err_frame` pulses once each. `cmd`, `chan` and `frame_count` unchanged. The long frame shows MISO = 0 after bit 16.
5. CHSEL = 9 with `C_channels` = 4 → next response is 0x9000.
6. Reset asserted at bit 7; release with CSN still low → no pulses, no MISO activity. The next full frame after CSN goes high then low responds with 0x0xxx for ch0; `frame_count` = 1. Also confirm `frame_count` wraps from 0xFFFF to 0.
